pipe_stage_fifo: RTL and testbench

- Parametrised elastic pipeline-stage buffer. It replaces the fixed single-entry stage registers between fetch/decode/execute/memory/writeback.
- Carries an opaque packed stage record (fetch_data_t, decode_data_t, execute_data_t, memory_data_t, ...) as DATA_W bits.
- Holds up to DEPTH records with a valid/ready handshake on both sides, supports a pipeline flush, and reports occupancy and stall statistics for the performance counters.

---
 rtl/pipe_stage_fifo.sv | 81 ++++++++
 tb/tb_pipe_stage_fifo.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_fifo.sv
// Elastic pipeline-stage buffer: DEPTH-entry circular FIFO carrying an opaque DATA_W record.
// One-cycle latency, no bypass; in_ready and out_valid come from registers only, so a pop never frees a slot in the same cycle.
module pipe_stage_fifo #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 2,
   parameter int CNT_W  = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [DATA_W-1:0]        in_data,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   input  logic                     out_ready,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count,
   output logic [CNT_W-1:0]         stall_cnt,
   output logic [CNT_W-1:0]         flush_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CW    = PTR_W + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic              push;
   logic              pop;

   assign in_ready  = (count != FULL);
   assign out_valid = (count != '0);
   assign out_data  = mem[rd_ptr];

   assign push = in_valid & in_ready & ~flush;
   assign pop  = out_valid & out_ready & ~flush;

   // Payload storage is never reset or cleared; out_data is only meaningful with out_valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (out_valid && !out_ready && !flush) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if (flush && (count != '0)) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
         end

         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Bench for pipe_stage_fifo: a DEPTH=2 and a DEPTH=4 instance, directed stimulus with
// per-instance expected-data queues drained by negedge monitors.
module tb_pipe_stage_fifo;

   logic clk;
   logic rst_n;

   logic        u2_in_valid, u2_in_ready, u2_out_valid, u2_out_ready, u2_flush;
   logic [63:0] u2_in_data, u2_out_data;
   logic [1:0]  u2_count;
   logic [31:0] u2_stall_cnt, u2_flush_cnt;

   logic        u4_in_valid, u4_in_ready, u4_out_valid, u4_out_ready, u4_flush;
   logic [63:0] u4_in_data, u4_out_data;
   logic [2:0]  u4_count;
   logic [31:0] u4_stall_cnt, u4_flush_cnt;

   logic [63:0] exp2[$];
   logic [63:0] exp4[$];

   int checks = 0;
   int errors = 0;
   int exp_stall4 = 0;

   pipe_stage_fifo #(.DATA_W(64), .DEPTH(2), .CNT_W(32)) u2 (
      .clk(clk), .reset(rst_n),
      .in_valid(u2_in_valid), .in_data(u2_in_data), .in_ready(u2_in_ready),
      .out_valid(u2_out_valid), .out_data(u2_out_data), .out_ready(u2_out_ready),
      .flush(u2_flush), .count(u2_count),
      .stall_cnt(u2_stall_cnt), .flush_cnt(u2_flush_cnt)
   );

   pipe_stage_fifo #(.DATA_W(64), .DEPTH(4), .CNT_W(32)) u4 (
      .clk(clk), .reset(rst_n),
      .in_valid(u4_in_valid), .in_data(u4_in_data), .in_ready(u4_in_ready),
      .out_valid(u4_out_valid), .out_data(u4_out_data), .out_ready(u4_out_ready),
      .flush(u4_flush), .count(u4_count),
      .stall_cnt(u4_stall_cnt), .flush_cnt(u4_flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // A pop happens on the next edge whenever the head is offered, taken and not flushed.
   always @(negedge clk) begin
      if (rst_n && u2_out_valid && u2_out_ready && !u2_flush) begin
         if (exp2.size() == 0) begin
            checks++; errors++;
            $display("FAIL u2_unexpected_pop: got %0h, required no output", u2_out_data);
         end else begin
            chk("u2_out_data", u2_out_data, exp2.pop_front());
         end
      end
      if (rst_n && u4_out_valid && u4_out_ready && !u4_flush) begin
         if (exp4.size() == 0) begin
            checks++; errors++;
            $display("FAIL u4_unexpected_pop: got %0h, required no output", u4_out_data);
         end else begin
            chk("u4_out_data", u4_out_data, exp4.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int sent;
      int m4;
      int cyc;
      logic push_m, pop_m;

      rst_n = 1'b0;
      u2_in_valid = 0; u2_in_data = '0; u2_out_ready = 0; u2_flush = 0;
      u4_in_valid = 0; u4_in_data = '0; u4_out_ready = 0; u4_flush = 0;
      #2;
      chk("rst_u2_in_ready", u2_in_ready, 1);
      chk("rst_u2_out_valid", u2_out_valid, 0);
      chk("rst_u2_count", u2_count, 0);
      chk("rst_u4_count", u4_count, 0);
      chk("rst_u4_stall", u4_stall_cnt, 0);
      #10 rst_n = 1'b1;
      step();

      // Latency and order on DEPTH=2
      u2_out_ready = 1; u2_in_valid = 1; u2_in_data = 64'hA; exp2.push_back(64'hA);
      step();
      chk("lat_count_c2", u2_count, 1);
      chk("lat_out_valid_c2", u2_out_valid, 1);
      u2_in_data = 64'hB; exp2.push_back(64'hB);
      step();
      chk("lat_count_c3", u2_count, 1);
      u2_in_valid = 0;
      step();
      chk("lat_count_end", u2_count, 0);
      chk("lat_stall", u2_stall_cnt, 0);

      // Full with simultaneous pop on DEPTH=2
      u2_out_ready = 0; u2_in_valid = 1; u2_in_data = 64'hC; exp2.push_back(64'hC);
      step();
      u2_in_data = 64'hD; exp2.push_back(64'hD);
      step();
      chk("full2_count", u2_count, 2);
      chk("full2_in_ready", u2_in_ready, 0);
      u2_out_ready = 1; u2_in_data = 64'hE; exp2.push_back(64'hE);
      step();
      chk("full2_pop_only_count", u2_count, 1);
      chk("full2_in_ready_after_pop", u2_in_ready, 1);
      step();
      chk("full2_push_pop_count", u2_count, 1);
      u2_in_valid = 0;
      step();
      chk("full2_drain_count", u2_count, 0);
      chk("full2_stall", u2_stall_cnt, 1);

      // Fill and stall on DEPTH=4
      u4_out_ready = 0;
      for (int i = 1; i <= 4; i++) begin
         u4_in_valid = 1; u4_in_data = 64'(i); exp4.push_back(64'(i));
         chk("fill_in_ready", u4_in_ready, 1);
         step();
      end
      u4_in_data = 64'h5; exp4.push_back(64'h5);
      chk("fill_full_count", u4_count, 4);
      for (int i = 0; i < 3; i++) begin
         chk("fill_in_ready_full", u4_in_ready, 0);
         step();
      end
      chk("fill_count_held", u4_count, 4);
      exp_stall4 = 6;
      chk("fill_stall", u4_stall_cnt, 32'(exp_stall4));
      u4_out_ready = 1;
      step();
      chk("fill_pop_only_count", u4_count, 3);
      chk("fill_in_ready_again", u4_in_ready, 1);
      step();
      u4_in_data = 64'h6; exp4.push_back(64'h6);
      step();
      chk("fill_push_pop_count", u4_count, 3);
      u4_in_valid = 0;
      step(); step(); step();
      chk("fill_drain_count", u4_count, 0);
      chk("fill_stall_after", u4_stall_cnt, 32'(exp_stall4));

      // Wrap-around stream of 20 records with random downstream back-pressure
      sent = 0; m4 = 0; cyc = 0;
      while ((sent < 20 || m4 != 0) && cyc < 300) begin
         u4_out_ready = (sent < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
         u4_in_valid  = (sent < 20);
         u4_in_data   = 64'h100 + 64'(sent);
         push_m = u4_in_valid && (m4 != 4);
         pop_m  = (m4 != 0) && u4_out_ready;
         if (m4 != 0 && !u4_out_ready) exp_stall4++;
         if (push_m) exp4.push_back(u4_in_data);
         step();
         m4   = m4 + int'(push_m) - int'(pop_m);
         sent = sent + int'(push_m);
         cyc++;
         chk("wrap_count", u4_count, 64'(m4));
      end
      u4_in_valid = 0;
      if (cyc >= 300) begin
         checks++; errors++;
         $display("FAIL wrap_timeout: got %0d sent, required 20 drained", sent);
      end
      chk("wrap_queue_empty", 64'(exp4.size()), 0);
      chk("wrap_stall", u4_stall_cnt, 32'(exp_stall4));

      // Flush with a simultaneous incoming record
      u4_out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         u4_in_valid = 1; u4_in_data = 64'h31 + 64'(i); exp4.push_back(u4_in_data);
         if (i != 0) exp_stall4++;
         step();
      end
      chk("flush_pre_count", u4_count, 3);
      u4_flush = 1; u4_in_data = 64'hFF;
      exp4.delete();
      step();
      chk("flush_count", u4_count, 0);
      chk("flush_out_valid", u4_out_valid, 0);
      chk("flush_cnt_one", u4_flush_cnt, 1);
      chk("flush_stall_gated", u4_stall_cnt, 32'(exp_stall4));
      u4_in_valid = 0;
      step();
      chk("flush_empty_cnt", u4_flush_cnt, 1);
      u4_flush = 0; u4_out_ready = 1;
      step();
      chk("flush_ff_not_stored", u4_out_valid, 0);

      // Asynchronous reset mid-operation
      u4_out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         u4_in_valid = 1; u4_in_data = 64'h41 + 64'(i);
         if (i != 0) exp_stall4++;
         step();
      end
      u4_in_valid = 0;
      step(); step(); step();
      exp_stall4 += 3;
      chk("prereset_count", u4_count, 3);
      chk("prereset_stall", u4_stall_cnt, 32'(exp_stall4));
      #2 rst_n = 1'b0;
      #1;
      chk("arst_count", u4_count, 0);
      chk("arst_out_valid", u4_out_valid, 0);
      chk("arst_in_ready", u4_in_ready, 1);
      chk("arst_stall", u4_stall_cnt, 0);
      chk("arst_flush_cnt", u4_flush_cnt, 0);
      rst_n = 1'b1;
      u4_in_valid = 1; u4_in_data = 64'h7; u4_out_ready = 1; exp4.push_back(64'h7);
      step();
      u4_in_valid = 0;
      chk("post_rst_out_valid", u4_out_valid, 1);
      chk("post_rst_out_data", u4_out_data, 64'h7);
      step();
      chk("post_rst_drain", u4_count, 0);
      chk("post_rst_queue_empty", 64'(exp4.size() + exp2.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
